// File: rtl/ex_operand_stage_if.sv
// ex_operand_stage_if: bundles the ID-side capture inputs, the EX/MEM and
// MEM/WB forwarding inputs, the hazard controls and the EX-side outputs of
// the ID/EX operand stage.
//   slave  : used by the stage itself (ID/forwarding/hazard in, EX out)
//   master : used by whatever drives the stage (ID/forwarding/hazard out, EX in)
interface ex_operand_stage_if;
    // hazard control
    logic        stall;
    logic        flush;
    // ID-side instruction fields
    logic        id_valid;
    logic [63:0] id_pc;
    logic [63:0] id_rs1_data;
    logic [63:0] id_rs2_data;
    logic [63:0] id_imm;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  id_rd;
    logic        id_alu_src;
    logic [1:0]  id_alu_op;
    logic [2:0]  id_funct3;
    logic        id_funct7b5;
    logic        id_reg_write;
    logic        id_mem_read;
    logic        id_mem_write;
    logic        id_branch;
    logic        id_mem_to_reg;
    // forwarding sources
    logic        exmem_reg_write;
    logic [4:0]  exmem_rd;
    logic [63:0] exmem_result;
    logic        memwb_reg_write;
    logic [4:0]  memwb_rd;
    logic [63:0] memwb_result;
    // EX-side outputs
    logic        ex_valid;
    logic [63:0] ex_a;
    logic [63:0] ex_b;
    logic [3:0]  ex_alu_ctl;
    logic [63:0] ex_store_data;
    logic [63:0] ex_pc;
    logic [63:0] ex_imm;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_branch;
    logic        ex_mem_to_reg;
    logic        ex_illegal;

    modport slave (
        input  stall, flush,
        input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
        input  id_rs1, id_rs2, id_rd, id_alu_src, id_alu_op, id_funct3, id_funct7b5,
        input  id_reg_write, id_mem_read, id_mem_write, id_branch, id_mem_to_reg,
        input  exmem_reg_write, exmem_rd, exmem_result,
        input  memwb_reg_write, memwb_rd, memwb_result,
        output ex_valid, ex_a, ex_b, ex_alu_ctl, ex_store_data, ex_pc, ex_imm, ex_rd,
        output ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_mem_to_reg, ex_illegal
    );

    modport master (
        output stall, flush,
        output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
        output id_rs1, id_rs2, id_rd, id_alu_src, id_alu_op, id_funct3, id_funct7b5,
        output id_reg_write, id_mem_read, id_mem_write, id_branch, id_mem_to_reg,
        output exmem_reg_write, exmem_rd, exmem_result,
        output memwb_reg_write, memwb_rd, memwb_result,
        input  ex_valid, ex_a, ex_b, ex_alu_ctl, ex_store_data, ex_pc, ex_imm, ex_rd,
        input  ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_mem_to_reg, ex_illegal
    );
endinterface

// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX pipeline register feeding the 64-bit ALU.
// Captures decoded ID fields, decodes the 2-bit main ALU op + funct bits into
// the 4-bit ALUop at capture time, and forwards EX/MEM / MEM/WB results onto
// the ALU operands and store data combinationally.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - ex_operand_stage_if.slave (ID fields, forwarding, stall/flush, EX outputs)
module ex_operand_stage (
    input  logic                   clk,
    input  logic                   rst,
    ex_operand_stage_if.slave      bus
);
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    logic        valid_q;
    logic [63:0] pc_q, imm_q, rs1_data_q, rs2_data_q;
    logic [4:0]  rs1_q, rs2_q, rd_q;
    logic        alu_src_q;
    logic [3:0]  alu_ctl_q;
    logic        illegal_q;
    logic        reg_write_q, mem_read_q, mem_write_q, branch_q, mem_to_reg_q;

    logic [3:0]  alu_ctl_d;
    logic        illegal_d;
    logic [63:0] fwd_rs1, fwd_rs2;

    // ALU control decode; unsupported combinations fall back to ADD and flag.
    always_comb begin
        alu_ctl_d = ALU_ADD;
        illegal_d = 1'b0;
        case (bus.id_alu_op)
            2'b00: alu_ctl_d = ALU_ADD;
            2'b01: alu_ctl_d = ALU_SUB;
            2'b10: begin
                case ({bus.id_funct7b5, bus.id_funct3})
                    4'b0_000: alu_ctl_d = ALU_ADD;
                    4'b1_000: alu_ctl_d = ALU_SUB;
                    4'b0_111: alu_ctl_d = ALU_AND;
                    4'b0_110: alu_ctl_d = ALU_OR;
                    4'b0_010: alu_ctl_d = ALU_SLT;
                    default:  illegal_d = 1'b1;
                endcase
            end
            default: begin
                // I-type arithmetic: funct7b5 is part of the immediate, ignore it
                case (bus.id_funct3)
                    3'b000:  alu_ctl_d = ALU_ADD;
                    3'b111:  alu_ctl_d = ALU_AND;
                    3'b110:  alu_ctl_d = ALU_OR;
                    3'b010:  alu_ctl_d = ALU_SLT;
                    default: illegal_d = 1'b1;
                endcase
            end
        endcase
    end

    // Forwarding: EX/MEM beats MEM/WB; x0 is never forwarded.
    always_comb begin
        if (bus.exmem_reg_write && bus.exmem_rd != 5'd0 && bus.exmem_rd == rs1_q)
            fwd_rs1 = bus.exmem_result;
        else if (bus.memwb_reg_write && bus.memwb_rd != 5'd0 && bus.memwb_rd == rs1_q)
            fwd_rs1 = bus.memwb_result;
        else
            fwd_rs1 = rs1_data_q;

        if (bus.exmem_reg_write && bus.exmem_rd != 5'd0 && bus.exmem_rd == rs2_q)
            fwd_rs2 = bus.exmem_result;
        else if (bus.memwb_reg_write && bus.memwb_rd != 5'd0 && bus.memwb_rd == rs2_q)
            fwd_rs2 = bus.memwb_result;
        else
            fwd_rs2 = rs2_data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q      <= 1'b0;
            pc_q         <= '0;
            imm_q        <= '0;
            rs1_data_q   <= '0;
            rs2_data_q   <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            rd_q         <= '0;
            alu_src_q    <= 1'b0;
            alu_ctl_q    <= '0;
            illegal_q    <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            branch_q     <= 1'b0;
            mem_to_reg_q <= 1'b0;
        end else if (bus.flush) begin
            // Bubble: control cleared, data fields left as they were.
            valid_q      <= 1'b0;
            alu_src_q    <= 1'b0;
            alu_ctl_q    <= '0;
            illegal_q    <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            branch_q     <= 1'b0;
            mem_to_reg_q <= 1'b0;
        end else if (bus.stall) begin
            // Absorb forwarded values so they survive the producers retiring.
            rs1_data_q <= fwd_rs1;
            rs2_data_q <= fwd_rs2;
        end else begin
            valid_q      <= bus.id_valid;
            pc_q         <= bus.id_pc;
            imm_q        <= bus.id_imm;
            rs1_data_q   <= bus.id_rs1_data;
            rs2_data_q   <= bus.id_rs2_data;
            rs1_q        <= bus.id_rs1;
            rs2_q        <= bus.id_rs2;
            rd_q         <= bus.id_rd;
            alu_src_q    <= bus.id_alu_src;
            alu_ctl_q    <= alu_ctl_d;
            illegal_q    <= illegal_d     & bus.id_valid;
            reg_write_q  <= bus.id_reg_write  & bus.id_valid;
            mem_read_q   <= bus.id_mem_read   & bus.id_valid;
            mem_write_q  <= bus.id_mem_write  & bus.id_valid;
            branch_q     <= bus.id_branch     & bus.id_valid;
            mem_to_reg_q <= bus.id_mem_to_reg & bus.id_valid;
        end
    end

    assign bus.ex_valid      = valid_q;
    assign bus.ex_a          = fwd_rs1;
    assign bus.ex_b          = alu_src_q ? imm_q : fwd_rs2;
    assign bus.ex_store_data = fwd_rs2;
    assign bus.ex_alu_ctl    = alu_ctl_q;
    assign bus.ex_pc         = pc_q;
    assign bus.ex_imm        = imm_q;
    assign bus.ex_rd         = rd_q;
    assign bus.ex_reg_write  = reg_write_q;
    assign bus.ex_mem_read   = mem_read_q;
    assign bus.ex_mem_write  = mem_write_q;
    assign bus.ex_branch     = branch_q;
    assign bus.ex_mem_to_reg = mem_to_reg_q;
    assign bus.ex_illegal    = illegal_q;
endmodule
